// File: rtl/bell_measurement_unit.sv
// Bell-state measurement unit.
// It snapshots four Q16.16 amplitudes and turns them into cumulative
// probability thresholds using one shared multiplier over four cycles.
// It then resolves NUM_SHOTS LFSR-driven projective measurements into a
// per-outcome histogram.
module bell_measurement_unit #(
    parameter int          NUM_SHOTS = 256,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [31:0] NORM_TOL  = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      amp_00,
    input  logic [31:0]      amp_01,
    input  logic [31:0]      amp_10,
    input  logic [31:0]      amp_11,
    output logic             busy,
    output logic             done,
    output logic [1:0]       outcome,
    output logic             outcome_valid,
    output logic [CNT_W-1:0] count_00,
    output logic [CNT_W-1:0] count_01,
    output logic [CNT_W-1:0] count_10,
    output logic [CNT_W-1:0] count_11,
    output logic             norm_err
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]      SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [CNT_W-1:0] LAST_SHOT = CNT_W'(NUM_SHOTS - 1);
    // Smallest square whose >>>16 exceeds 1.0, i.e. the saturation point.
    localparam logic [63:0]      SAT_SQ    = 64'h0000_0001_0001_0000;
    localparam logic [18:0]      ONE_C     = 19'h1_0000;

    // Elaboration-time guard on the shot count range.
    generate
        if (NUM_SHOTS < 1 || NUM_SHOTS > (2 ** CNT_W) - 1) begin : g_bad_shots
            $error("bell_measurement_unit: NUM_SHOTS out of range 1..2^CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PROB, S_SHOT, S_DONE} state_t;

    state_t            state_q;
    logic [31:0]       amp_q [4];
    logic [1:0]        k_q;
    logic [18:0]       cum_q [3];
    logic [15:0]       lfsr_q;
    logic [CNT_W-1:0]  shot_q;
    logic [CNT_W-1:0]  count_q [4];
    logic              busy_q;
    logic              done_q;
    logic [1:0]        outcome_q;
    logic              outcome_valid_q;
    logic              norm_err_q;

    logic signed [31:0] amp_sel_d;
    logic [63:0]        sq_d;
    logic [16:0]        p_d;
    logic [18:0]        cum_prev_d;
    logic [18:0]        cum_d;
    logic [18:0]        dev_d;
    logic               norm_bad_d;
    logic [18:0]        r_d;
    logic [1:0]         pick_d;
    logic [15:0]        lfsr_next_d;
    logic               accept_d;

    // Probability datapath, shot resolution and LFSR next state.
    always_comb begin
        amp_sel_d   = $signed(amp_q[k_q]);
        sq_d        = amp_sel_d * amp_sel_d;
        p_d         = (sq_d >= SAT_SQ) ? 17'h1_0000 : sq_d[32:16];
        case (k_q)
            2'd1:    cum_prev_d = cum_q[0];
            2'd2:    cum_prev_d = cum_q[1];
            2'd3:    cum_prev_d = cum_q[2];
            default: cum_prev_d = '0;
        endcase
        cum_d       = cum_prev_d + {2'b00, p_d};
        dev_d       = (cum_d >= ONE_C) ? (cum_d - ONE_C) : (ONE_C - cum_d);
        norm_bad_d  = {13'b0, dev_d} > NORM_TOL;
        r_d         = {3'b000, lfsr_q};
        // Any mass missing below 1.0 falls through to |11>.
        if (r_d < cum_q[0])      pick_d = 2'd0;
        else if (r_d < cum_q[1]) pick_d = 2'd1;
        else if (r_d < cum_q[2]) pick_d = 2'd2;
        else                     pick_d = 2'd3;
        lfsr_next_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        accept_d    = start && (state_q == S_IDLE || state_q == S_DONE);
    end

    // Control FSM with all state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            k_q             <= '0;
            lfsr_q          <= SEED_EFF;
            shot_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            outcome_q       <= '0;
            outcome_valid_q <= 1'b0;
            norm_err_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                amp_q[i]   <= '0;
                count_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) cum_q[i] <= '0;
        end else begin
            outcome_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_d) begin
                        amp_q[0]   <= amp_00;
                        amp_q[1]   <= amp_01;
                        amp_q[2]   <= amp_10;
                        amp_q[3]   <= amp_11;
                        for (int i = 0; i < 4; i++) count_q[i] <= '0;
                        norm_err_q <= 1'b0;
                        lfsr_q     <= SEED_EFF;
                        k_q        <= '0;
                        shot_q     <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= S_PROB;
                    end
                end
                S_PROB: begin
                    case (k_q)
                        2'd0:    cum_q[0] <= cum_d;
                        2'd1:    cum_q[1] <= cum_d;
                        2'd2:    cum_q[2] <= cum_d;
                        default: begin
                            norm_err_q <= norm_bad_d;
                            state_q    <= S_SHOT;
                        end
                    endcase
                    k_q <= k_q + 2'd1;
                end
                S_SHOT: begin
                    outcome_q       <= pick_d;
                    outcome_valid_q <= 1'b1;
                    count_q[pick_d] <= count_q[pick_d] + 1'b1;
                    lfsr_q          <= lfsr_next_d;
                    shot_q          <= shot_q + 1'b1;
                    if (shot_q == LAST_SHOT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign outcome       = outcome_q;
    assign outcome_valid = outcome_valid_q;
    assign norm_err      = norm_err_q;
    assign count_00      = count_q[0];
    assign count_01      = count_q[1];
    assign count_10      = count_q[2];
    assign count_11      = count_q[3];

endmodule

// File: tb/tb_bell_measurement_unit.sv
// Scoreboard bench for bell_measurement_unit: stimulus pushes expected shot
// outcomes and run results; a monitor pops and compares them as they appear.
module tb_bell_measurement_unit;

    localparam int N_SHOTS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] amp_00 = '0, amp_01 = '0, amp_10 = '0, amp_11 = '0;
    logic        busy, done, outcome_valid, norm_err;
    logic [1:0]  outcome;
    logic [15:0] count_00, count_01, count_10, count_11;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int shot_seen = 0;
    bit done_prev = 1'b0;

    typedef struct {
        int c0;
        int c1;
        int c2;
        int c3;
        bit nerr;
        int drive;
    } res_t;

    res_t       res_q[$];
    logic [1:0] shot_q[$];

    bell_measurement_unit dut (
        .clk(clk), .rst(rst), .start(start),
        .amp_00(amp_00), .amp_01(amp_01), .amp_10(amp_10), .amp_11(amp_11),
        .busy(busy), .done(done), .outcome(outcome), .outcome_valid(outcome_valid),
        .count_00(count_00), .count_01(count_01), .count_10(count_10), .count_11(count_11),
        .norm_err(norm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Reference model: probabilities as integer squares, cumulative
    // thresholds, then a walk of the LFSR sequence.
    task automatic model_push(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3, input int drive);
        logic [31:0] a[4];
        longint p[4];
        longint thr[4];
        longint tot, dev;
        int cnt[4];
        int unsigned lfsr;
        int o;
        res_t r;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        for (int k = 0; k < 4; k++) begin
            p[k] = (longint'($signed(a[k])) * longint'($signed(a[k]))) / 65536;
            if (p[k] > 65536) p[k] = 65536;
            thr[k] = (k == 0) ? p[k] : thr[k-1] + p[k];
            cnt[k] = 0;
        end
        tot = thr[3];
        dev = (tot > 65536) ? tot - 65536 : 65536 - tot;
        lfsr = 32'hACE1;
        for (int s = 0; s < N_SHOTS; s++) begin
            o = 3;
            for (int k = 2; k >= 0; k--) if (longint'(lfsr) < thr[k]) o = k;
            shot_q.push_back(2'(o));
            cnt[o]++;
            lfsr = (lfsr / 2) ^ (((lfsr % 2) == 1) ? 32'hB400 : 32'h0);
        end
        r.c0 = cnt[0]; r.c1 = cnt[1]; r.c2 = cnt[2]; r.c3 = cnt[3];
        r.nerr = (dev > 256);
        r.drive = drive;
        res_q.push_back(r);
    endtask

    // Issue a run at a falling edge; returns once the unit is in SHOT.
    task automatic start_run(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
        bit nerr_req;
        amp_00 = a0; amp_01 = a1; amp_10 = a2; amp_11 = a3;
        start = 1'b1;
        shot_seen = 0;
        model_push(a0, a1, a2, a3, cyc);
        nerr_req = res_q[res_q.size()-1].nerr;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the run must use the snapshot.
        amp_00 = $urandom; amp_01 = $urandom; amp_10 = $urandom; amp_11 = $urandom;
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        check("accept_counts_cleared", {count_00, count_01, count_10, count_11}, 0);
        repeat (4) @(negedge clk);
        check("norm_err_at_shot_entry", norm_err, nerr_req);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 600) begin
            @(negedge clk);
            g++;
        end
        check("done_within_bound", (g < 600), 1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_amp();
        logic [31:0] v;
        v = 32'($urandom_range(0, 32'h14000));
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Monitor: compares every shot and every completed run.
    always @(negedge clk) begin
        if (!rst) begin
            if (outcome_valid) begin
                if (shot_q.size() == 0) begin
                    failures++;
                    checks++;
                    $display("FAIL unexpected_pulse actual=%0h expected=none", outcome);
                end else begin
                    check("shot_outcome", outcome, shot_q.pop_front());
                end
                shot_seen++;
            end
            if (done && !done_prev) begin
                if (res_q.size() == 0) begin
                    failures++;
                    checks++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("count_00", count_00, r.c0);
                    check("count_01", count_01, r.c1);
                    check("count_10", count_10, r.c2);
                    check("count_11", count_11, r.c3);
                    check("norm_err", norm_err, r.nerr);
                    check("done_latency", cyc - r.drive, 261);
                    check("missing_pulses", shot_q.size(), 0);
                    check("busy_in_done", busy, 0);
                    $display("run drive=%0d counts=%0d/%0d/%0d/%0d norm_err=%0b",
                             r.drive, count_00, count_01, count_10, count_11, norm_err);
                end
            end
        end
        done_prev = done;
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_counts", {count_00, count_01, count_10, count_11}, 0);
        check("rst_outcome", {outcome_valid, outcome, norm_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Pure |00>.
        start_run(32'h0001_0000, 0, 0, 0);
        wait_done();
        // Bell state, twice (same seed gives same counts).
        repeat (2) begin
            start_run(32'h0000_B505, 0, 0, 32'h0000_B505);
            wait_done();
        end
        // Negative amplitude on |10>.
        start_run(0, 0, 32'hFFFF_0000, 0);
        wait_done();
        // All zero: norm error, everything to |11>.
        start_run(0, 0, 0, 0);
        wait_done();
        // Start spam during SHOT must be ignored.
        start_run(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 1) == 1);
        end
        start = 1'b0;
        wait_done();
        // Random amplitudes, including saturating magnitudes.
        repeat (3) begin
            start_run(rnd_amp(), rnd_amp(), rnd_amp(), rnd_amp());
            wait_done();
        end

        // Reset at shot 100.
        start_run(32'h0000_B505, 0, 0, 32'h0000_B505);
        g = 0;
        while (shot_seen < 100 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("reach_shot_100", (g < 400), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_counts", {count_00, count_01, count_10, count_11}, 0);
        check("async_rst_outcome", {outcome_valid, outcome, norm_err}, 0);
        shot_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {busy, done}, 0);
        start_run(32'h0001_0000, 0, 0, 0);
        wait_done();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
